// File: rtl/sifive_event_merge.sv
// Two-source event merger: per-source saturating pending counters feeding one
// registered valid/ready output channel with round-robin arbitration.
module sifive_event_merge #(
  parameter int CNT_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in0_pulse,
  input  logic             in1_pulse,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_src,
  output logic [CNT_W-1:0] pend0,
  output logic [CNT_W-1:0] pend1,
  output logic             ovf0,
  output logic             ovf1,
  input  logic             ovf_clr
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] pend0_q, pend0_d;
  logic [CNT_W-1:0] pend1_q, pend1_d;
  logic             out_valid_q, out_valid_d;
  logic             out_src_q, out_src_d;
  logic             ovf0_q, ovf0_d;
  logic             ovf1_q, ovf1_d;
  logic             last_q, last_d;

  logic has0, has1, load, grant, dec0, dec1;

  always_comb begin
    has0  = (pend0_q != '0);
    has1  = (pend1_q != '0);
    load  = (!out_valid_q || out_ready) && (has0 || has1);
    // On a tie the source not served last wins; otherwise whichever is pending.
    if (has0 && has1) grant = ~last_q;
    else              grant = !has0;
    dec0 = load && (grant == 1'b0);
    dec1 = load && (grant == 1'b1);

    out_valid_d = out_valid_q;
    out_src_d   = out_src_q;
    last_d      = last_q;
    if (load) begin
      out_valid_d = 1'b1;
      out_src_d   = grant;
      last_d      = grant;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    pend0_d = pend0_q;
    ovf0_d  = ovf0_q;
    if (ovf_clr) ovf0_d = 1'b0;
    if (in0_pulse && !dec0) begin
      if (pend0_q == CNT_MAX) ovf0_d = 1'b1;
      else                    pend0_d = pend0_q + CNT_ONE;
    end else if (!in0_pulse && dec0) begin
      pend0_d = pend0_q - CNT_ONE;
    end

    pend1_d = pend1_q;
    ovf1_d  = ovf1_q;
    if (ovf_clr) ovf1_d = 1'b0;
    if (in1_pulse && !dec1) begin
      if (pend1_q == CNT_MAX) ovf1_d = 1'b1;
      else                    pend1_d = pend1_q + CNT_ONE;
    end else if (!in1_pulse && dec1) begin
      pend1_d = pend1_q - CNT_ONE;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pend0_q     <= '0;
      pend1_q     <= '0;
      out_valid_q <= 1'b0;
      out_src_q   <= 1'b0;
      ovf0_q      <= 1'b0;
      ovf1_q      <= 1'b0;
      last_q      <= 1'b1;
    end else begin
      pend0_q     <= pend0_d;
      pend1_q     <= pend1_d;
      out_valid_q <= out_valid_d;
      out_src_q   <= out_src_d;
      ovf0_q      <= ovf0_d;
      ovf1_q      <= ovf1_d;
      last_q      <= last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_src   = out_src_q;
  assign pend0     = pend0_q;
  assign pend1     = pend1_q;
  assign ovf0      = ovf0_q;
  assign ovf1      = ovf1_q;

endmodule

// File: tb/tb_sifive_event_merge.sv
// Directed bench for sifive_event_merge: handshake, fairness, backpressure,
// saturation/overflow and mid-operation reset with hand-computed expectations.
module tb_sifive_event_merge;

  localparam int CNT_W = 4;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             in0_pulse = 1'b0;
  logic             in1_pulse = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic             out_src;
  logic [CNT_W-1:0] pend0;
  logic [CNT_W-1:0] pend1;
  logic             ovf0;
  logic             ovf1;
  logic             ovf_clr = 1'b0;

  int checks = 0;
  int errors = 0;

  sifive_event_merge #(.CNT_W(CNT_W)) dut (
    .clock     (clock),
    .reset     (reset),
    .in0_pulse (in0_pulse),
    .in1_pulse (in1_pulse),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_src   (out_src),
    .pend0     (pend0),
    .pend1     (pend1),
    .ovf0      (ovf0),
    .ovf1      (ovf1),
    .ovf_clr   (ovf_clr)
  );

  always #5 clock = ~clock;

  // One clock edge, then settle so outputs are sampled away from the edge.
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; in0_pulse = 1'b0; in1_pulse = 1'b0;
    out_ready = 1'b0; ovf_clr = 1'b0;
    cyc();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (out_valid !== 1'b0 || out_src !== 1'b0 || pend0 !== 4'd0 || pend1 !== 4'd0 ||
        ovf0 !== 1'b0 || ovf1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got v=%b s=%b p0=%0d p1=%0d o0=%b o1=%b, want all 0",
               out_valid, out_src, pend0, pend1, ovf0, ovf1);
    end
  endtask

  task automatic test_single();
    do_reset();
    out_ready = 1'b1;
    in0_pulse = 1'b1;
    cyc();
    in0_pulse = 1'b0;
    checks++;
    if (pend0 !== 4'd1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_pend: got p0=%0d v=%b, want p0=1 v=0", pend0, out_valid);
    end
    cyc();
    checks++;
    if (out_valid !== 1'b1 || out_src !== 1'b0 || pend0 !== 4'd0) begin
      errors++;
      $display("FAIL single_out: got v=%b s=%b p0=%0d, want v=1 s=0 p0=0", out_valid, out_src, pend0);
    end
    cyc();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_release: got v=%b, want 0", out_valid);
    end
  endtask

  task automatic test_round_robin();
    logic [4:0] exp_src;
    do_reset();
    in0_pulse = 1'b1; in1_pulse = 1'b1;
    repeat (3) cyc();
    in0_pulse = 1'b0; in1_pulse = 1'b0;
    // First tie loaded source 0 while both kept counting.
    checks++;
    if (out_valid !== 1'b1 || out_src !== 1'b0 || pend0 !== 4'd2 || pend1 !== 4'd3) begin
      errors++;
      $display("FAIL rr_hold: got v=%b s=%b p0=%0d p1=%0d, want v=1 s=0 p0=2 p1=3",
               out_valid, out_src, pend0, pend1);
    end
    out_ready = 1'b1;
    exp_src = 5'b10101;
    for (int i = 0; i < 5; i++) begin
      cyc();
      checks++;
      if (out_valid !== 1'b1 || out_src !== exp_src[4-i]) begin
        errors++;
        $display("FAIL rr_seq[%0d]: got v=%b s=%b, want v=1 s=%b", i, out_valid, out_src, exp_src[4-i]);
      end
    end
    cyc();
    checks++;
    if (out_valid !== 1'b0 || pend0 !== 4'd0 || pend1 !== 4'd0) begin
      errors++;
      $display("FAIL rr_drain: got v=%b p0=%0d p1=%0d, want 0 0 0", out_valid, pend0, pend1);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    in1_pulse = 1'b1;
    cyc();
    in1_pulse = 1'b0;
    cyc();
    checks++;
    if (out_valid !== 1'b1 || out_src !== 1'b1 || pend1 !== 4'd0) begin
      errors++;
      $display("FAIL bp_setup: got v=%b s=%b p1=%0d, want v=1 s=1 p1=0", out_valid, out_src, pend1);
    end
    in1_pulse = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      checks++;
      if (out_valid !== 1'b1 || out_src !== 1'b1 || pend1 !== 4'(i + 1)) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got v=%b s=%b p1=%0d, want v=1 s=1 p1=%0d",
                 i, out_valid, out_src, pend1, i + 1);
      end
    end
    in1_pulse = 1'b0;
    out_ready = 1'b1;
    cyc();
    checks++;
    if (out_valid !== 1'b1 || out_src !== 1'b1 || pend1 !== 4'd9) begin
      errors++;
      $display("FAIL bp_release: got v=%b s=%b p1=%0d, want v=1 s=1 p1=9", out_valid, out_src, pend1);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    in0_pulse = 1'b1;
    repeat (16) cyc();
    checks++;
    if (pend0 !== 4'd15 || ovf0 !== 1'b0 || out_valid !== 1'b1 || out_src !== 1'b0) begin
      errors++;
      $display("FAIL sat_fill: got p0=%0d o0=%b v=%b s=%b, want p0=15 o0=0 v=1 s=0",
               pend0, ovf0, out_valid, out_src);
    end
    cyc();
    in0_pulse = 1'b0;
    checks++;
    if (pend0 !== 4'd15 || ovf0 !== 1'b1 || ovf1 !== 1'b0) begin
      errors++;
      $display("FAIL sat_drop: got p0=%0d o0=%b o1=%b, want p0=15 o0=1 o1=0", pend0, ovf0, ovf1);
    end
    ovf_clr = 1'b1;
    cyc();
    ovf_clr = 1'b0;
    checks++;
    if (ovf0 !== 1'b0 || pend0 !== 4'd15) begin
      errors++;
      $display("FAIL ovf_clear: got o0=%b p0=%0d, want o0=0 p0=15", ovf0, pend0);
    end
    in0_pulse = 1'b1; out_ready = 1'b1;
    cyc();
    in0_pulse = 1'b0; out_ready = 1'b0;
    checks++;
    if (pend0 !== 4'd15 || ovf0 !== 1'b0 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL sat_inc_dec: got p0=%0d o0=%b v=%b, want p0=15 o0=0 v=1", pend0, ovf0, out_valid);
    end
    in0_pulse = 1'b1; ovf_clr = 1'b1;
    cyc();
    in0_pulse = 1'b0; ovf_clr = 1'b0;
    checks++;
    if (ovf0 !== 1'b1 || pend0 !== 4'd15) begin
      errors++;
      $display("FAIL ovf_set_wins: got o0=%b p0=%0d, want o0=1 p0=15", ovf0, pend0);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    in0_pulse = 1'b1; in1_pulse = 1'b1;
    repeat (3) cyc();
    in1_pulse = 1'b0;
    repeat (3) cyc();
    in0_pulse = 1'b0;
    checks++;
    if (pend0 !== 4'd5 || pend1 !== 4'd3 || out_valid !== 1'b1 || out_src !== 1'b0) begin
      errors++;
      $display("FAIL mid_setup: got p0=%0d p1=%0d v=%b s=%b, want 5 3 1 0", pend0, pend1, out_valid, out_src);
    end
    reset = 1'b1; in0_pulse = 1'b1; in1_pulse = 1'b1; out_ready = 1'b1;
    cyc();
    reset = 1'b0; out_ready = 1'b0;
    checks++;
    if (pend0 !== 4'd0 || pend1 !== 4'd0 || out_valid !== 1'b0 || ovf0 !== 1'b0 || ovf1 !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got p0=%0d p1=%0d v=%b o0=%b o1=%b, want all 0",
               pend0, pend1, out_valid, ovf0, ovf1);
    end
    cyc();
    in0_pulse = 1'b0; in1_pulse = 1'b0;
    cyc();
    checks++;
    if (out_valid !== 1'b1 || out_src !== 1'b0 || pend0 !== 4'd0 || pend1 !== 4'd1) begin
      errors++;
      $display("FAIL mid_first_tie: got v=%b s=%b p0=%0d p1=%0d, want v=1 s=0 p0=0 p1=1",
               out_valid, out_src, pend0, pend1);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_saturation();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
